// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: one requester's valid/ready request and response-pulse bundle
interface dmem_arbiter_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [3:0]  req_size;
  logic        rsp_valid;
  logic [63:0] rsp_rdata;
  logic        rsp_err;
  modport master(
    output req_valid, req_we, req_addr, req_wdata, req_size,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );
  modport slave(
    input  req_valid, req_we, req_addr, req_wdata, req_size,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin sharing of the single-port data memory between two requesters
module dmem_arbiter #(
  parameter int MEM_BYTES = 1024
) (
  input  logic           clk,
  input  logic           reset_n,
  dmem_arbiter_if.slave  r0,
  dmem_arbiter_if.slave  r1,
  output logic [63:0]    mem_address,
  output logic           mem_write_enable,
  output logic           mem_read_enable,
  output logic [63:0]    mem_write_data,
  output logic [3:0]     mem_xfer_size,
  input  logic [63:0]    mem_read_data
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t      state, state_n;
  logic        rr_ptr, owner, we, err;
  logic [63:0] addr, wdata, rdata0, rdata1, rd_mask, rd_val;
  logic [3:0]  size;
  logic        win0, win1, hs, sel_we, sel_err;
  logic [63:0] sel_addr, sel_wdata;
  logic [3:0]  sel_size;
  // arbitration, request checking, next state and read-data shaping
  always_comb begin
    win1      = r1.req_valid & (~r0.req_valid | rr_ptr);
    win0      = r0.req_valid & ~win1;
    hs        = (state == IDLE) & (win0 | win1);
    sel_we    = win1 ? r1.req_we : r0.req_we;
    sel_addr  = win1 ? r1.req_addr : r0.req_addr;
    sel_wdata = win1 ? r1.req_wdata : r0.req_wdata;
    sel_size  = win1 ? r1.req_size : r0.req_size;
    sel_err   = !(sel_size inside {4'd1, 4'd2, 4'd4, 4'd8})
              || (|(sel_addr & (64'(sel_size) - 64'd1)))
              || (({1'b0, sel_addr} + 65'(sel_size)) > 65'(MEM_BYTES));
    state_n   = state == ACCESS ? RESP :
                state == RESP   ? IDLE :
                hs              ? (sel_err ? RESP : ACCESS) : IDLE;
    rd_mask   = size == 4'd1 ? 64'hFF :
                size == 4'd2 ? 64'hFFFF :
                size == 4'd4 ? 64'hFFFF_FFFF : '1;
    rd_val    = (state == ACCESS && !we) ? (mem_read_data & rd_mask) : '0;
  end
  assign r0.req_ready      = reset_n & hs & win0;
  assign r1.req_ready      = reset_n & hs & win1;
  assign r0.rsp_valid      = (state == RESP) & ~owner;
  assign r1.rsp_valid      = (state == RESP) & owner;
  assign r0.rsp_err        = (state == RESP) & ~owner & err;
  assign r1.rsp_err        = (state == RESP) & owner & err;
  assign r0.rsp_rdata      = rdata0;
  assign r1.rsp_rdata      = rdata1;
  assign mem_address       = addr;
  assign mem_write_data    = wdata;
  assign mem_xfer_size     = size;
  assign mem_read_enable   = (state == ACCESS) & ~we;
  assign mem_write_enable  = (state == ACCESS) & we;
  // state register and round-robin pointer handed to the other requester after each response
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      rr_ptr <= 1'b0;
    end else begin
      state <= state_n;
      if (state == RESP) rr_ptr <= ~owner;
    end
  end
  // latch the accepted request so the requester is free once handshaken
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner <= 1'b0;
      we    <= 1'b0;
      err   <= 1'b0;
      addr  <= '0;
      wdata <= '0;
      size  <= 4'd8;
    end else if (hs) begin
      owner <= win1;
      we    <= sel_we;
      err   <= sel_err;
      addr  <= sel_addr;
      wdata <= sel_wdata;
      size  <= sel_size;
    end
  end
  // per-requester read data: loaded at end of ACCESS, or cleared when an error goes straight to RESP
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata0 <= '0;
      rdata1 <= '0;
    end else begin
      if ((state == ACCESS && !owner) || (hs && sel_err && win0)) rdata0 <= rd_val;
      if ((state == ACCESS && owner) || (hs && sel_err && win1)) rdata1 <= rd_val;
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: randomized and directed checking of dmem_arbiter against a transaction-level model
module tb_dmem_arbiter;
  localparam int MEM_BYTES = 1024;
  localparam int AW = $clog2(MEM_BYTES);
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;
  dmem_arbiter_if r0_if();
  dmem_arbiter_if r1_if();
  logic [63:0] mem_address, mem_write_data, mem_read_data;
  logic        mem_write_enable, mem_read_enable;
  logic [3:0]  mem_xfer_size;
  dmem_arbiter #(.MEM_BYTES(MEM_BYTES)) dut (
    .clk(clk), .reset_n(reset_n), .r0(r0_if), .r1(r1_if),
    .mem_address(mem_address), .mem_write_enable(mem_write_enable),
    .mem_read_enable(mem_read_enable), .mem_write_data(mem_write_data),
    .mem_xfer_size(mem_xfer_size), .mem_read_data(mem_read_data)
  );
  int checks = 0;
  int errors = 0;
  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask
  // datamem stand-in: combinational read, write of low xfer_size bytes at posedge
  logic [7:0] dmem [MEM_BYTES];
  logic seeded = 1'b0;
  always_comb begin
    mem_read_data = '0;
    for (int i = 0; i < 8; i++) mem_read_data[8*i +: 8] = dmem[AW'(mem_address[AW-1:0] + AW'(i))];
  end
  always @(posedge clk) begin
    if (!seeded) begin
      for (int i = 0; i < MEM_BYTES; i++) dmem[i] <= 8'(i * 37 + 5);
      seeded <= 1'b1;
    end else if (mem_write_enable) begin
      for (int i = 0; i < int'(mem_xfer_size); i++) dmem[AW'(mem_address[AW-1:0] + AW'(i))] <= mem_write_data[8*i +: 8];
    end
  end
  // reference model: byte array, one outstanding transaction, preference bit
  logic [7:0] ref_mem [MEM_BYTES];
  typedef struct {
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [3:0]  size;
    logic        err;
    logic [63:0] rdata;
    int          owner;
    int          hs;
    int          due;
  } req_t;
  req_t pend[$];
  int   grants[$];
  logic ptr = 1'b0;
  int   cyc = 0;
  logic [63:0] last_rdata;
  logic        last_err;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic model_err(logic [63:0] a, logic [3:0] s);
    if (!(s inside {4'd1, 4'd2, 4'd4, 4'd8})) return 1'b1;
    if (a % 64'(s) != 0) return 1'b1;
    return a > 64'(MEM_BYTES) - 64'(s);
  endfunction
  function automatic logic [63:0] model_read(logic [63:0] a, logic [3:0] s);
    logic [63:0] r = '0;
    for (int i = 0; i < int'(s); i++) r[8*i +: 8] = ref_mem[int'(a) + i];
    return r;
  endfunction
  req_t e;
  logic free, v0, v1, w0, w1, acc_now, due_now;
  always @(negedge clk) begin
    if (!reset_n) begin
      pend.delete();
      ptr = 1'b0;
    end else begin
      free = pend.size() == 0;
      v0 = r0_if.req_valid;
      v1 = r1_if.req_valid;
      w1 = v1 && (!v0 || ptr);
      w0 = v0 && !w1;
      check("ready0", r0_if.req_ready, free && w0);
      check("ready1", r1_if.req_ready, free && w1);
      acc_now = !free && !pend[0].err && cyc == pend[0].hs;
      check("mem_we", mem_write_enable, acc_now && pend[0].we);
      check("mem_re", mem_read_enable, acc_now && !pend[0].we);
      if (acc_now) begin
        check("mem_addr", mem_address, pend[0].addr);
        check("mem_size", mem_xfer_size, pend[0].size);
        if (pend[0].we) check("mem_wdata", mem_write_data, pend[0].wdata);
      end
      due_now = !free && cyc == pend[0].due;
      check("rsp_valid0", r0_if.rsp_valid, due_now && pend[0].owner == 0);
      check("rsp_valid1", r1_if.rsp_valid, due_now && pend[0].owner == 1);
      if (due_now) begin
        e = pend.pop_front();
        last_err   = e.owner == 1 ? r1_if.rsp_err : r0_if.rsp_err;
        last_rdata = e.owner == 1 ? r1_if.rsp_rdata : r0_if.rsp_rdata;
        check("rsp_err", last_err, e.err);
        check("rsp_rdata", last_rdata, e.rdata);
        if (e.we && !e.err)
          for (int i = 0; i < int'(e.size); i++) ref_mem[int'(e.addr) + i] = e.wdata[8*i +: 8];
        ptr = e.owner == 0;
      end
      if (free && (w0 || w1)) begin
        e.owner = w1 ? 1 : 0;
        e.we    = w1 ? r1_if.req_we : r0_if.req_we;
        e.addr  = w1 ? r1_if.req_addr : r0_if.req_addr;
        e.wdata = w1 ? r1_if.req_wdata : r0_if.req_wdata;
        e.size  = w1 ? r1_if.req_size : r0_if.req_size;
        e.err   = model_err(e.addr, e.size);
        e.rdata = (e.err || e.we) ? 64'd0 : model_read(e.addr, e.size);
        e.hs    = cyc + 1;
        e.due   = e.err ? e.hs : e.hs + 1;
        pend.push_back(e);
        grants.push_back(e.owner);
      end
    end
  end
  task automatic drive(int p, logic v, logic we, logic [63:0] a, logic [63:0] d, logic [3:0] s);
    if (p == 0) begin
      r0_if.req_valid = v; r0_if.req_we = we; r0_if.req_addr = a; r0_if.req_wdata = d; r0_if.req_size = s;
    end else begin
      r1_if.req_valid = v; r1_if.req_we = we; r1_if.req_addr = a; r1_if.req_wdata = d; r1_if.req_size = s;
    end
  endtask
  function automatic logic rdy(int p);
    return p == 1 ? r1_if.req_ready : r0_if.req_ready;
  endfunction
  task automatic req(int p, logic we, logic [63:0] a, logic [63:0] d, logic [3:0] s, int maxw);
    logic acc = 1'b0;
    drive(p, 1'b1, we, a, d, s);
    for (int w = 0; w <= maxw && !acc; w++) begin
      @(negedge clk);
      acc = rdy(p);
      @(posedge clk);
      #1;
    end
    drive(p, 1'b0, we, a, d, s);
    if (maxw >= 20) check("handshake", acc, 1'b1);
  endtask
  task automatic wait_rsp();
    repeat (3) @(posedge clk);
    #1;
  endtask
  task automatic check_reset();
    check("rst_ready0", r0_if.req_ready, 0);
    check("rst_ready1", r1_if.req_ready, 0);
    check("rst_rv0", r0_if.rsp_valid, 0);
    check("rst_rv1", r1_if.rsp_valid, 0);
    check("rst_err0", r0_if.rsp_err, 0);
    check("rst_err1", r1_if.rsp_err, 0);
    check("rst_rd0", r0_if.rsp_rdata, 0);
    check("rst_rd1", r1_if.rsp_rdata, 0);
    check("rst_en", {mem_write_enable, mem_read_enable}, 0);
    check("rst_addr", mem_address, 0);
    check("rst_wdata", mem_write_data, 0);
    check("rst_size", mem_xfer_size, 8);
  endtask
  task automatic rand_req(int p);
    logic [3:0]  s;
    logic [63:0] a;
    int          k;
    repeat ($urandom_range(0, 2)) begin
      @(posedge clk);
      #1;
    end
    k = $urandom_range(0, 99);
    s = k < 90 ? 4'(1 << $urandom_range(0, 3)) : 4'($urandom_range(0, 15));
    a = 64'($urandom_range(0, 255)) & ~(64'(s) - 64'd1);
    k = $urandom_range(0, 99);
    if (k < 8) a = 64'($urandom_range(MEM_BYTES - 24, MEM_BYTES - 1));
    else if (k < 10) a = 64'hFFFF_FFFF_FFFF_FFF8;
    else if (k < 15) a = 64'($urandom_range(0, 255));
    req(p, 1'($urandom_range(0, 1)), a, {32'($urandom), 32'($urandom)}, s,
        $urandom_range(0, 9) == 0 ? 0 : 50);
  endtask
  logic [63:0] pre;
  initial begin
    for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = 8'(i * 37 + 5);
    drive(0, 1'b0, 1'b0, '0, '0, 4'd8);
    drive(1, 1'b0, 1'b0, '0, '0, 4'd8);
    repeat (2) @(posedge clk);
    #1;
    check_reset();
    @(negedge clk);
    #2 reset_n = 1'b1;
    @(posedge clk);
    #1;
    grants.delete();
    for (int r = 0; r < 3; r++)
      fork
        req(0, 1'b0, 64'(8 * r), '0, 4'd8, 50);
        req(1, 1'b0, 64'(8 * r + 64), '0, 4'd8, 50);
      join
    wait_rsp();
    check("rr_count", grants.size(), 6);
    for (int i = 0; i < 6 && i < grants.size(); i++) check("rr_order", grants[i], i % 2);
    req(0, 1'b1, 64'h10, 64'h1122334455667788, 4'd8, 50);
    wait_rsp();
    req(0, 1'b0, 64'h10, '0, 4'd8, 50);
    wait_rsp();
    check("t1_rdata", last_rdata, 64'h1122334455667788);
    req(0, 1'b1, 64'h22, 64'h0000_0000_0000_BEEF, 4'd2, 50);
    wait_rsp();
    check("t2_wr_rdata", last_rdata, 0);
    req(1, 1'b0, 64'h20, '0, 4'd8, 50);
    wait_rsp();
    check("t2_lanes", last_rdata[31:16], 16'hBEEF);
    req(0, 1'b0, 64'h6, '0, 4'd4, 50);
    wait_rsp();
    check("t4_misalign", last_err, 1);
    req(1, 1'b0, 64'h8, '0, 4'd3, 50);
    wait_rsp();
    check("t4_size3", last_err, 1);
    req(0, 1'b0, 64'h3FC, '0, 4'd8, 50);
    wait_rsp();
    check("t4_range", {last_err, last_rdata}, {1'b1, 64'd0});
    pre = model_read(64'h40, 4'd8);
    req(0, 1'b1, 64'h40, 64'hDEAD_BEEF_0BAD_F00D, 4'd8, 50);
    check("t5_in_access", mem_write_enable, 1);
    reset_n = 1'b0;
    #1;
    check_reset();
    @(posedge clk);
    @(negedge clk);
    #2 reset_n = 1'b1;
    @(posedge clk);
    #1;
    req(0, 1'b0, 64'h40, '0, 4'd8, 50);
    wait_rsp();
    check("t5_no_commit", last_rdata, pre);
    fork
      for (int k = 0; k < 4000; k++) rand_req(0);
      for (int k = 0; k < 4000; k++) rand_req(1);
    join
    wait_rsp();
    check("pending_empty", pend.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
